// File: rtl/synth_pkg.sv
// Shared synth definitions: voice states, default voice/note widths and the age ceiling.
package synth_pkg;
  localparam int NUM_VOICES_DEF = 4;
  localparam int NOTE_W_DEF     = 7;
  localparam int AGE_W          = 8;
  localparam logic [AGE_W-1:0] AGE_MAX = 8'd255;

  typedef enum logic [1:0] {
    V_IDLE,
    V_HELD,
    V_RELEASING,
    V_RETRIG
  } voice_state_t;
endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake into the voice allocator (valid/ready, one event per transfer).
interface voice_allocator_if #(
  parameter int NOTE_W = synth_pkg::NOTE_W_DEF
);
  logic              NoteValid;
  logic              NoteReady;
  logic              NoteOn;
  logic [NOTE_W-1:0] NoteNum;

  modport master (output NoteValid, NoteOn, NoteNum, input NoteReady);
  modport slave  (input NoteValid, NoteOn, NoteNum, output NoteReady);
endinterface

// File: rtl/voice_select.sv
// Combinational voice choice for a note-on: same-note voice, else lowest IDLE, else oldest
// RELEASING, else (when STEAL) oldest HELD; age ties resolve to the lowest index.
module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter bit STEAL      = 1'b0,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  voice_state_t [NUM_VOICES-1:0]             state,
  input  logic         [NUM_VOICES-1:0][AGE_W-1:0]  age,
  input  logic         [NUM_VOICES-1:0][NOTE_W-1:0] note,
  input  logic         [NOTE_W-1:0]                 note_num,
  output logic                                      hit,
  output logic         [IDX_W-1:0]                  sel_idx,
  output logic                                      sel_retrig
);
  logic             match_vld, idle_vld, rel_vld, held_vld;
  logic [IDX_W-1:0] match_idx, idle_idx, rel_idx, held_idx;
  logic [AGE_W-1:0] rel_age, held_age;

  always_comb begin
    match_vld = 1'b0; match_idx = '0;
    idle_vld  = 1'b0; idle_idx  = '0;
    rel_vld   = 1'b0; rel_idx   = '0; rel_age  = '0;
    held_vld  = 1'b0; held_idx  = '0; held_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_vld && (state[i] == V_HELD || state[i] == V_RELEASING) && note[i] == note_num) begin
        match_vld = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!idle_vld && state[i] == V_IDLE) begin
        idle_vld = 1'b1;
        idle_idx = IDX_W'(i);
      end
      // Strict '>' keeps the lowest index on equal ages.
      if (state[i] == V_RELEASING && (!rel_vld || age[i] > rel_age)) begin
        rel_vld = 1'b1;
        rel_idx = IDX_W'(i);
        rel_age = age[i];
      end
      if (state[i] == V_HELD && (!held_vld || age[i] > held_age)) begin
        held_vld = 1'b1;
        held_idx = IDX_W'(i);
        held_age = age[i];
      end
    end

    hit        = 1'b1;
    sel_idx    = match_idx;
    sel_retrig = 1'b1;
    if (match_vld) begin
      sel_idx = match_idx;
    end else if (idle_vld) begin
      sel_idx    = idle_idx;
      sel_retrig = 1'b0;
    end else if (rel_vld) begin
      sel_idx = rel_idx;
    end else if (STEAL && held_vld) begin
      sel_idx = held_idx;
    end else begin
      hit = 1'b0;
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice gate and note out to ADSR generators.
// Define VOICE_STEAL_EN to retrigger the oldest HELD voice instead of dropping when all are busy.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF
) (
  input  logic                         Clock,
  input  logic                         Reset,
  voice_allocator_if.slave             note,
  output logic [NUM_VOICES-1:0]        Gate,
  input  logic [NUM_VOICES-1:0]        Running,
  output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
  output logic                         Dropped
);
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  localparam int IDX_W = $clog2(NUM_VOICES);

  voice_state_t [NUM_VOICES-1:0]             state_q;
  logic         [NUM_VOICES-1:0][AGE_W-1:0]  age_q;
  logic         [NUM_VOICES-1:0][NOTE_W-1:0] note_q;
  logic                                      ready_q;
  logic                                      dropped_q;
  logic                                      xfer;
  logic                                      hit;
  logic                                      sel_retrig;
  logic         [IDX_W-1:0]                  sel_idx;

  assign xfer           = note.NoteValid && ready_q;
  assign note.NoteReady = ready_q;
  assign VoiceNote      = note_q;
  assign Dropped        = dropped_q;

  always_comb begin
    Gate = '0;
    for (int i = 0; i < NUM_VOICES; i++) Gate[i] = (state_q[i] == V_HELD);
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .STEAL      (STEAL)
  ) u_select (
    .state      (state_q),
    .age        (age_q),
    .note       (note_q),
    .note_num   (note.NoteNum),
    .hit        (hit),
    .sel_idx    (sel_idx),
    .sel_retrig (sel_retrig)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) state_q[i] <= V_IDLE;
      age_q     <= '0;
      note_q    <= '0;
      ready_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      ready_q   <= !xfer;
      dropped_q <= xfer && note.NoteOn && !hit;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (state_q[i] == V_RETRIG)
          state_q[i] <= V_HELD;
        else if (state_q[i] == V_RELEASING && !Running[i])
          state_q[i] <= V_IDLE;
        if (xfer && !note.NoteOn && state_q[i] == V_HELD && note_q[i] == note.NoteNum)
          state_q[i] <= V_RELEASING;
        // The event's choice overrides a same-cycle Running fall on the chosen voice.
        if (xfer && note.NoteOn && hit) begin
          if (IDX_W'(i) == sel_idx) begin
            state_q[i] <= sel_retrig ? V_RETRIG : V_HELD;
            note_q[i]  <= note.NoteNum;
            age_q[i]   <= '0;
          end else if (age_q[i] != AGE_MAX) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, meaning the number of ADSR voices driven (2..16).
REQ-002 SHALL have parameter NOTE_W, default 7, meaning the note number width.
REQ-003 SHALL have port Clock  input  1  system clock; all state changes on posedge Clock.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port NoteValid  input  1  note event present.
REQ-006 SHALL have port NoteReady  output  1  allocator can accept an event this cycle.
REQ-007 SHALL have port NoteOn  input  1  event type: 1 = note-on, 0 = note-off.
REQ-008 SHALL have port NoteNum  input  NOTE_W  note number of the event.
REQ-009 SHALL have port Gate  output  NUM_VOICES  per-voice gate to each envelope generator.
REQ-010 SHALL have port Running  input  NUM_VOICES  per-voice envelope-active flag from each envelope generator.
REQ-011 SHALL have port VoiceNote  output  NUM_VOICES*NOTE_W  note assigned to each voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-012 SHALL have port Dropped  output  1  one-cycle pulse when an accepted event is discarded.

Function
REQ-013 SHALL transfer an event only on a cycle where NoteValid and NoteReady are both 1.
REQ-014 SHALL drive NoteReady 0 for exactly the one cycle after each transfer, and 1 otherwise when out of reset, giving at most one event per 2 cycles.
REQ-015 SHALL keep per-voice state IDLE (Gate 0), HELD (Gate 1), RELEASING (Gate 0, awaiting Running 0) and RETRIG (Gate 0 for exactly one cycle, then HELD).
REQ-016 SHALL move a RELEASING voice to IDLE on the cycle after Running[i] is sampled 0.
REQ-017 SHALL, for a note-on whose NoteNum matches a HELD or RELEASING voice, move that voice to RETRIG so that Gate[i] is 0 at cycle N+1 and 1 at N+2, where N is the transfer cycle.
REQ-018 SHALL otherwise assign a note-on to the lowest-index IDLE voice, else to the RELEASING voice with the greatest age, and SHALL set that voice's Gate 1 and VoiceNote at N+1.
REQ-019 SHALL break age ties by choosing the lowest index.
REQ-020 SHALL, when the voice assigned under REQ-018 is RELEASING, use RETRIG so that a fresh Gate rising edge is produced.
REQ-021 SHALL keep an 8-bit age per voice: on each note-on the assigned voice's age becomes 0, and every other voice's age increments, saturating at 255.
REQ-022 SHALL, for a note-off, move every HELD voice whose note equals NoteNum to RELEASING (Gate 0 at N+1).
REQ-023 SHALL ignore a note-off that matches no HELD voice, with no Dropped pulse.
REQ-024 SHALL base selection on state registered before cycle N; a Running fall in cycle N SHALL NOT change that choice.
REQ-025 SHALL hold VoiceNote[i] unchanged when voice i becomes IDLE.

Reset
REQ-026 SHALL, while Reset is 0 at a posedge, set every voice to IDLE, Gate 0, VoiceNote 0, all ages 0, Dropped 0 and NoteReady 0.
REQ-027 SHALL drive NoteReady 1 on the first cycle after Reset returns to 1.
REQ-028 SHALL let a reset asserted during RETRIG or a pending transfer discard all in-flight activity.

Configuration
REQ-029 SHALL, with macro VOICE_STEAL_EN defined, assign a note-on with no IDLE or RELEASING voice to the oldest HELD voice via RETRIG, with VoiceNote updated at N+1 and no Dropped pulse.
REQ-030 SHALL, without VOICE_STEAL_EN, discard such a note-on, pulse Dropped at N+1, and leave all voice state and ages unchanged.

Structure
REQ-031 SHALL take the voice-state enum, NOTE_W default, NUM_VOICES default and AGE_MAX = 255 from shared package synth_pkg.
REQ-032 SHALL implement selection (lowest IDLE, oldest RELEASING, oldest HELD, tie to lowest index) in a combinational sub-module voice_select.

Verification
REQ-033 SHALL cover: reset, then note-on 60 -> Gate = 4'b0001, VoiceNote[0] = 60 one cycle after transfer, and NoteReady low for that cycle.
REQ-034 SHALL cover: note-ons 60, 62, 64, 65, then note-off 62 -> Gate = 4'b1101; once Running[1] goes 0, voice 1 is IDLE.
REQ-035 SHALL cover: note-on 60 while voice 0 holds 60 -> Gate[0] reads 0 then 1 on consecutive cycles; other gates unchanged.
REQ-036 SHALL cover: all 4 voices HELD (60 first), note-on 70 -> with VOICE_STEAL_EN, voice 0 retriggers with VoiceNote 70; without it, Dropped pulses once and Gate stays 4'b1111.
REQ-037 SHALL cover: voices 2 and 3 RELEASING (3 older), note-on 50 -> voice 3 is chosen.
REQ-038 SHALL cover: Reset low mid-RETRIG -> Gate = 0, VoiceNote = 0, NoteReady = 0, then NoteReady = 1 the cycle after release.
